// File: rtl/nios2_oci_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : nios2_oci_mem_arbiter
// Purpose : Shares the single-port OCI debug RAM between the JTAG debug path
//           and the CPU Avalon-MM debug slave. JTAG strobes are latched into a
//           one-deep pending register. Arbitration is round-robin, and each
//           access is sequenced as address phase, one read-latency cycle and
//           completion.
// Config  : OCI_MEM_PROTECT_EN - when defined, Avalon writes at or above
//           PROT_BASE are dropped unless the CPU is in debug mode.
// Revision: 1.0 - initial release
// ============================================================================
module nios2_oci_mem_arbiter #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] PROT_BASE = 8'hC0
) (
    input  logic              clk,
    input  logic              reset_n,
    // JTAG debug path
    input  logic              jtag_req,
    input  logic              jtag_we,
    input  logic [ADDR_W-1:0] jtag_addr,
    input  logic [31:0]       jtag_wdata,
    output logic              jtag_done,
    output logic [31:0]       jtag_rdata,
    output logic              jtag_overrun,
    // Avalon-MM debug slave
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [31:0]       av_writedata,
    output logic              av_waitrequest,
    output logic [31:0]       av_readdata,
    input  logic              debugack,
    output logic              prot_violation,
    // OCI RAM macro
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ACC  = 2'd1;
    localparam logic [1:0] c_RDAT = 2'd2;

    logic [1:0]        r_state;
    logic              r_pend;
    logic              r_pend_we;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [31:0]       r_pend_wdata;
    logic              r_last_av;     // 1: last grant went to Avalon
    logic              r_gnt_av;      // source of the access in flight
    logic              r_gnt_we;      // access in flight is a write
    logic [31:0]       r_jtag_rdata;
    logic [31:0]       r_av_rdata;
    logic              r_overrun;

    logic              w_idle;
    logic              w_acc;
    logic              w_rdat;
    logic              w_j_req;
    logic              w_a_req;
    logic              w_grant_j;
    logic              w_grant_a;
    logic              w_j_we;
    logic [ADDR_W-1:0] w_j_addr;
    logic [31:0]       w_j_wdata;
    logic              w_prot_drop;

    assign w_idle = (r_state == c_IDLE);
    assign w_acc  = (r_state == c_ACC);
    assign w_rdat = (r_state == c_RDAT);

    // A live strobe is visible to the arbiter in the same cycle, so a JTAG
    // request can be granted without first spending a cycle in the pending
    // register; the pending copy always takes priority over a live strobe.
    assign w_j_req   = r_pend | jtag_req;
    assign w_a_req   = av_read | av_write;
    assign w_grant_j = w_idle & w_j_req & (~w_a_req | r_last_av);
    assign w_grant_a = w_idle & w_a_req & (~w_j_req | ~r_last_av);

    assign w_j_we    = r_pend ? r_pend_we    : jtag_we;
    assign w_j_addr  = r_pend ? r_pend_addr  : jtag_addr;
    assign w_j_wdata = r_pend ? r_pend_wdata : jtag_wdata;

`ifdef OCI_MEM_PROTECT_EN
    logic r_prot;

    assign w_prot_drop = w_grant_a & av_write & (av_address >= PROT_BASE) & ~debugack;

    // Sticky flag: an Avalon write to the protected window was discarded
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prot <= 1'b0;
        end else if (w_prot_drop) begin
            r_prot <= 1'b1;
        end
    end

    assign prot_violation = r_prot;
`else
    logic w_unused_cfg;

    assign w_prot_drop    = 1'b0;
    assign prot_violation = 1'b0;
    assign w_unused_cfg   = debugack ^ (^PROT_BASE);
`endif

    // JTAG pending register: capture strobes not consumed directly, flag overruns
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend       <= 1'b0;
            r_pend_we    <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_wdata <= '0;
            r_overrun    <= 1'b0;
        end else if (jtag_req) begin
            if (r_pend && !w_grant_j) begin
                r_overrun <= 1'b1;
            end else if (!(w_grant_j && !r_pend)) begin
                r_pend       <= 1'b1;
                r_pend_we    <= jtag_we;
                r_pend_addr  <= jtag_addr;
                r_pend_wdata <= jtag_wdata;
            end
        end else if (w_grant_j) begin
            r_pend <= 1'b0;
        end
    end

    // Access sequencer: grant in IDLE, drive the RAM in ACC, capture read data in RDAT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_IDLE;
            r_last_av    <= 1'b1;
            r_gnt_av     <= 1'b0;
            r_gnt_we     <= 1'b0;
            r_jtag_rdata <= '0;
            r_av_rdata   <= '0;
            ram_addr     <= '0;
            ram_we       <= 1'b0;
            ram_wdata    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_grant_j || w_grant_a) begin
                        r_state   <= c_ACC;
                        r_last_av <= w_grant_a;
                        r_gnt_av  <= w_grant_a;
                        if (w_grant_a) begin
                            r_gnt_we  <= av_write;
                            ram_addr  <= av_address;
                            ram_wdata <= av_writedata;
                            ram_we    <= av_write & ~w_prot_drop;
                        end else begin
                            r_gnt_we  <= w_j_we;
                            ram_addr  <= w_j_addr;
                            ram_wdata <= w_j_wdata;
                            ram_we    <= w_j_we;
                        end
                    end
                end
                c_ACC: begin
                    ram_we  <= 1'b0;
                    r_state <= r_gnt_we ? c_IDLE : c_RDAT;
                end
                c_RDAT: begin
                    if (r_gnt_av) begin
                        r_av_rdata <= ram_rdata;
                    end else begin
                        r_jtag_rdata <= ram_rdata;
                    end
                    r_state <= c_IDLE;
                end
                default: begin
                    ram_we  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Completions are decoded from state so a reset silences them at once;
    // read data bypasses the capture register in the completing cycle.
    assign jtag_done      = (w_acc & ~r_gnt_av & r_gnt_we) | (w_rdat & ~r_gnt_av);
    assign av_waitrequest = ~((w_acc & r_gnt_av & r_gnt_we) | (w_rdat & r_gnt_av));
    assign jtag_rdata     = (w_rdat & ~r_gnt_av) ? ram_rdata : r_jtag_rdata;
    assign av_readdata    = (w_rdat & r_gnt_av) ? ram_rdata : r_av_rdata;
    assign jtag_overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_nios2_oci_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_nios2_oci_mem_arbiter
// Purpose : Scoreboard bench for nios2_oci_mem_arbiter. Stimulus threads push
//           expected completions per source; a monitor pops and compares.
// Revision: 1.0 - initial release
// ============================================================================
module tb_nios2_oci_mem_arbiter;

    typedef struct packed {
        logic        we;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        jtag_req;
    logic        jtag_we;
    logic [7:0]  jtag_addr;
    logic [31:0] jtag_wdata;
    logic        jtag_done;
    logic [31:0] jtag_rdata;
    logic        jtag_overrun;
    logic [7:0]  av_address;
    logic        av_read;
    logic        av_write;
    logic [31:0] av_writedata;
    logic        av_waitrequest;
    logic [31:0] av_readdata;
    logic        debugack;
    logic        prot_violation;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int checks   = 0;
    int failures = 0;
    int done_j   = 0;
    int done_a   = 0;
    int we_cnt   = 0;

    exp_t        jq[$];
    exp_t        aq[$];
    int          order_q[$];
    logic [31:0] model [256];
    logic [31:0] ram   [256];
    logic        fill_en;
    logic [7:0]  fill_addr;

    nios2_oci_mem_arbiter #(.ADDR_W(8), .PROT_BASE(8'hC0)) dut (
        .clk(clk), .reset_n(reset_n),
        .jtag_req(jtag_req), .jtag_we(jtag_we), .jtag_addr(jtag_addr),
        .jtag_wdata(jtag_wdata), .jtag_done(jtag_done), .jtag_rdata(jtag_rdata),
        .jtag_overrun(jtag_overrun),
        .av_address(av_address), .av_read(av_read), .av_write(av_write),
        .av_writedata(av_writedata), .av_waitrequest(av_waitrequest),
        .av_readdata(av_readdata), .debugack(debugack),
        .prot_violation(prot_violation),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [7:0] a);
        return {8'h5A, a, ~a, a ^ 8'h3C};
    endfunction

    // Synchronous single-port RAM, one cycle read latency
    always @(posedge clk) begin
        if (fill_en) begin
            ram[fill_addr] <= init_val(fill_addr);
        end else if (ram_we) begin
            ram[ram_addr] <= ram_wdata;
        end
        ram_rdata <= ram[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop the expected response for every completion seen
    always @(negedge clk) begin
        if (reset_n) begin
            if (ram_we) we_cnt++;
            if (jtag_done) begin
                exp_t e;
                done_j++;
                order_q.push_back(0);
                if (jq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL jtag_unexpected_done: got done=1 expected no completion");
                end else begin
                    e = jq.pop_front();
                    if (!e.we) chk("jtag_rdata", jtag_rdata, e.data);
                end
            end
            if (!av_waitrequest) begin
                exp_t e;
                done_a++;
                order_q.push_back(1);
                if (aq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL av_unexpected_completion: got waitrequest=0 expected 1");
                end else begin
                    e = aq.pop_front();
                    if (!e.we) chk("av_readdata", av_readdata, e.data);
                end
            end
        end
    end

    // One JTAG access; called at posedge+1, returns at posedge+1
    task automatic jtag_xfer(input logic we, input logic [7:0] addr, input logic [31:0] data,
                             output int lat);
        jq.push_back('{we: we, data: (we ? 32'h0 : model[addr])});
        if (we) model[addr] = data;
        jtag_req = 1'b1; jtag_we = we; jtag_addr = addr; jtag_wdata = data;
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (jtag_done) break;
            if (lat >= 40) begin
                chk("jtag_timeout", 32'(lat), 32'd0);
                break;
            end
            @(posedge clk); #1;
            jtag_req = 1'b0;
        end
        @(posedge clk); #1;
        jtag_req = 1'b0;
    endtask

    // One Avalon transfer; 'lands' is 0 when the write is expected to be dropped
    task automatic av_xfer(input logic we, input logic [7:0] addr, input logic [31:0] data,
                           input logic lands, output int lat);
        aq.push_back('{we: we, data: (we ? 32'h0 : model[addr])});
        if (we && lands) model[addr] = data;
        av_address = addr; av_write = we; av_read = ~we; av_writedata = data;
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (!av_waitrequest) break;
            if (lat >= 40) begin
                chk("av_timeout", 32'(lat), 32'd0);
                break;
            end
        end
        @(posedge clk); #1;
        av_read = 1'b0; av_write = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        idle_cycles(2);
        reset_n = 1'b1;
        idle_cycles(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int we0;
        int d0;
        reset_n = 1'b0; jtag_req = 1'b0; jtag_we = 1'b0; jtag_addr = '0; jtag_wdata = '0;
        av_address = '0; av_read = 1'b0; av_write = 1'b0; av_writedata = '0; debugack = 1'b0;
        fill_en = 1'b1; fill_addr = '0;
        for (int i = 0; i < 256; i++) model[i] = init_val(8'(i));
        for (int i = 0; i < 256; i++) begin
            fill_addr = 8'(i);
            @(posedge clk); #1;
        end
        fill_en = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_jtag_done", jtag_done, 0);
        chk("rst_jtag_rdata", jtag_rdata, 0);
        chk("rst_overrun", jtag_overrun, 0);
        chk("rst_waitrequest", av_waitrequest, 1);
        chk("rst_av_readdata", av_readdata, 0);
        chk("rst_prot", prot_violation, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle_cycles(1);

        // JTAG write then read-back
        we0 = we_cnt;
        jtag_xfer(1'b1, 8'h10, 32'hDEADBEEF, lat);
        chk("jtag_wr_latency", lat, 2);
        chk("jtag_wr_ram_we_pulses", we_cnt - we0, 1);
        jtag_xfer(1'b0, 8'h10, 32'h0, lat);
        chk("jtag_rd_latency", lat, 3);
        idle_cycles(2);
        chk("jtag_rdata_held", jtag_rdata, 32'hDEADBEEF);

        // Avalon write then read-back
        av_xfer(1'b1, 8'h20, 32'h12345678, 1'b1, lat);
        chk("av_wr_latency", lat, 2);
        av_xfer(1'b0, 8'h20, 32'h0, 1'b1, lat);
        chk("av_rd_latency", lat, 3);

        // Simultaneous requests after reset: JTAG first, then strict alternation
        pulse_reset();
        order_q.delete();
        fork
            begin
                int l;
                for (int i = 0; i < 5; i++) jtag_xfer(1'b1, 8'(8'h30 + i), $urandom, l);
            end
            begin
                int l;
                for (int i = 0; i < 5; i++) av_xfer(1'b1, 8'(8'h90 + i), $urandom, 1'b1, l);
            end
        join
        chk("arb_count", order_q.size(), 10);
        for (int i = 0; i < order_q.size(); i++) chk("arb_order", order_q[i], i % 2);

        // Randomized concurrent traffic in disjoint address windows
        fork
            begin
                int l;
                for (int i = 0; i < 30; i++) begin
                    idle_cycles($urandom_range(0, 3));
                    jtag_xfer(1'($urandom), 8'($urandom_range(0, 127)), $urandom, l);
                end
            end
            begin
                int l;
                for (int i = 0; i < 30; i++) begin
                    idle_cycles($urandom_range(0, 3));
                    debugack = 1'($urandom);
                    av_xfer(1'($urandom), 8'($urandom_range(128, 191)), $urandom, 1'b1, l);
                end
            end
        join
        chk("rand_no_overrun", jtag_overrun, 0);

        // Second strobe while the first is pending behind an Avalon read
        d0 = done_j;
        fork
            av_xfer(1'b0, 8'h88, 32'h0, 1'b1, lat);
            begin
                @(posedge clk); #1;
                jq.push_back('{we: 1'b1, data: 32'h0});
                model[8'h40] = 32'hCAFE0040;
                jtag_req = 1'b1; jtag_we = 1'b1; jtag_addr = 8'h40; jtag_wdata = 32'hCAFE0040;
                @(posedge clk); #1;
                jtag_addr = 8'h41; jtag_wdata = 32'hBAD00041;
                @(posedge clk); #1;
                jtag_req = 1'b0;
            end
        join
        for (int i = 0; i < 20 && jq.size() != 0; i++) @(negedge clk);
        @(posedge clk); #1;
        chk("overrun_flag", jtag_overrun, 1);
        chk("overrun_single_exec", done_j - d0, 1);
        jtag_xfer(1'b0, 8'h41, 32'h0, lat);
        jtag_xfer(1'b0, 8'h40, 32'h0, lat);

        // Protected window write
`ifdef OCI_MEM_PROTECT_EN
        debugack = 1'b0;
        we0 = we_cnt;
        av_xfer(1'b1, 8'hC5, 32'h11112222, 1'b0, lat);
        chk("prot_wr_latency", lat, 2);
        chk("prot_no_ram_we", we_cnt - we0, 0);
        chk("prot_flag", prot_violation, 1);
        av_xfer(1'b0, 8'hC5, 32'h0, 1'b1, lat);
        debugack = 1'b1;
        we0 = we_cnt;
        av_xfer(1'b1, 8'hC5, 32'h33334444, 1'b1, lat);
        chk("prot_debug_ram_we", we_cnt - we0, 1);
        av_xfer(1'b0, 8'hC5, 32'h0, 1'b1, lat);
`else
        debugack = 1'b0;
        we0 = we_cnt;
        av_xfer(1'b1, 8'hC5, 32'h11112222, 1'b1, lat);
        chk("noprot_wr_latency", lat, 2);
        chk("noprot_ram_we", we_cnt - we0, 1);
        chk("noprot_flag", prot_violation, 0);
        av_xfer(1'b0, 8'hC5, 32'h0, 1'b1, lat);
`endif

        // Reset while a read sits in RDAT: abandoned, no completion afterwards
        d0 = done_j + done_a;
        av_address = 8'h20; av_read = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        reset_n = 1'b0; av_read = 1'b0;
        #1;
        chk("midrst_waitrequest", av_waitrequest, 1);
        chk("midrst_av_readdata", av_readdata, 0);
        chk("midrst_ram_addr", ram_addr, 0);
        chk("midrst_jtag_rdata", jtag_rdata, 0);
        chk("midrst_overrun", jtag_overrun, 0);
        chk("midrst_prot", prot_violation, 0);
        idle_cycles(3);
        reset_n = 1'b1;
        idle_cycles(5);
        chk("midrst_no_completion", done_j + done_a - d0, 0);

        chk("jq_empty", jq.size(), 0);
        chk("aq_empty", aq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
